// File: rtl/up_packet_interface.sv
// Byte-serial microprocessor packet port: collects command bytes over a 4-wire
// handshake, hands them to the register bank, then streams the response back.
module up_packet_interface #(
  parameter int N_WRITE_BYTES  = 6,
  parameter int N_READ_BYTES   = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      async_uP_start,
  input  logic                      async_uP_handshake_1,
  input  logic                      async_uP_RW,
  input  logic [7:0]                uP_data_in,
  output logic [7:0]                uP_data_out,
  output logic                      uP_data_oe,
  output logic                      uP_handshake_2,
  output logic                      uP_ack,
  output logic [8*N_WRITE_BYTES-1:0] cmd_packet,
  output logic                      cmd_valid,
  input  logic [8*N_READ_BYTES-1:0] rsp_packet,
  input  logic                      rsp_valid,
  output logic                      busy,
  output logic                      error
);

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(N_WRITE_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_R = IDX_W'(N_READ_BYTES - 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    W_WAIT_H1_HI,
    W_WAIT_H1_LO,
    EXEC,
    R_SETUP,
    R_WAIT_H1_HI,
    R_WAIT_H1_LO,
    DONE
  } state_t;

  state_t state_q, state_n;

  logic [SYNC_STAGES-1:0] start_sync, h1_sync, rw_sync;
  logic s_start, s_h1, s_rw, s_start_d, start_edge;

  logic [IDX_W-1:0] index_q, index_n, index_inc;
  logic [TW-1:0]    timer_q;
  logic [8*N_READ_BYTES-1:0] rsp_buf;
  logic [7:0] data_out_q, data_out_n, next_rd_byte;
  logic hs2_q, hs2_n, ack_q, ack_n, oe_q, oe_n;
  logic cmd_valid_n, error_n;
  logic wr_latch, rsp_latch, abort, restart;
  logic busy_state, read_state, timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_sync <= '0;
      h1_sync    <= '0;
      rw_sync    <= '0;
      s_start_d  <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], async_uP_start};
      h1_sync    <= {h1_sync[SYNC_STAGES-2:0], async_uP_handshake_1};
      rw_sync    <= {rw_sync[SYNC_STAGES-2:0], async_uP_RW};
      s_start_d  <= s_start;
    end
  end

  assign s_start    = start_sync[SYNC_STAGES-1];
  assign s_h1       = h1_sync[SYNC_STAGES-1];
  assign s_rw       = rw_sync[SYNC_STAGES-1];
  assign start_edge = s_start & ~s_start_d;

  assign busy_state  = (state_q != IDLE) && (state_q != DONE);
  assign read_state  = (state_q == R_SETUP) || (state_q == R_WAIT_H1_HI) ||
                       (state_q == R_WAIT_H1_LO);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && busy_state && (timer_q == TIMER_LAST);
  assign restart     = busy_state && start_edge;
  assign index_inc   = index_q + 1'b1;

  always_comb begin
    next_rd_byte = 8'h00;
    for (int i = 0; i < N_READ_BYTES; i++) begin
      if (index_inc == IDX_W'(i)) next_rd_byte = rsp_buf[8*i +: 8];
    end
  end

  // Next-state and next-output logic; abort conditions override the normal flow.
  always_comb begin
    state_n     = state_q;
    index_n     = index_q;
    hs2_n       = hs2_q;
    ack_n       = ack_q;
    oe_n        = oe_q;
    data_out_n  = data_out_q;
    cmd_valid_n = 1'b0;
    error_n     = 1'b0;
    wr_latch    = 1'b0;
    rsp_latch   = 1'b0;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_n = W_WAIT_H1_HI;
          index_n = '0;
        end
      end
      W_WAIT_H1_HI: begin
        if (s_h1) begin
          if (s_rw) begin
            wr_latch = 1'b1;
            hs2_n    = 1'b1;
            state_n  = W_WAIT_H1_LO;
          end else begin
            abort = 1'b1;
          end
        end
      end
      W_WAIT_H1_LO: begin
        if (!s_h1) begin
          hs2_n = 1'b0;
          if (index_q == LAST_W) begin
            cmd_valid_n = 1'b1;
            state_n     = EXEC;
          end else begin
            index_n = index_inc;
            state_n = W_WAIT_H1_HI;
          end
        end
      end
      EXEC: begin
        // First response byte goes out on entry to R_SETUP for one clock of setup.
        if (rsp_valid) begin
          rsp_latch  = 1'b1;
          index_n    = '0;
          data_out_n = rsp_packet[7:0];
          oe_n       = 1'b1;
          state_n    = R_SETUP;
        end
      end
      R_SETUP: begin
        hs2_n   = 1'b1;
        state_n = R_WAIT_H1_HI;
      end
      R_WAIT_H1_HI: begin
        if (s_h1) begin
          hs2_n   = 1'b0;
          state_n = R_WAIT_H1_LO;
        end
      end
      R_WAIT_H1_LO: begin
        if (!s_h1) begin
          if (index_q == LAST_R) begin
            oe_n       = 1'b0;
            data_out_n = 8'h00;
            ack_n      = 1'b1;
            state_n    = DONE;
          end else begin
            index_n    = index_inc;
            data_out_n = next_rd_byte;
            oe_n       = 1'b1;
            state_n    = R_SETUP;
          end
        end
      end
      DONE: begin
        if (start_edge) begin
          ack_n   = 1'b0;
          index_n = '0;
          state_n = W_WAIT_H1_HI;
        end
      end
      default: state_n = IDLE;
    endcase

    if (read_state && s_rw) abort = 1'b1;
    if (timeout_hit || restart) abort = 1'b1;

    if (abort) begin
      hs2_n       = 1'b0;
      ack_n       = 1'b0;
      oe_n        = 1'b0;
      data_out_n  = 8'h00;
      cmd_valid_n = 1'b0;
      error_n     = 1'b1;
      wr_latch    = 1'b0;
      rsp_latch   = 1'b0;
      index_n     = '0;
      state_n     = restart ? W_WAIT_H1_HI : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Registered outputs, packet storage and the wait-state timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_q    <= '0;
      timer_q    <= '0;
      hs2_q      <= 1'b0;
      ack_q      <= 1'b0;
      oe_q       <= 1'b0;
      data_out_q <= 8'h00;
      cmd_valid  <= 1'b0;
      error      <= 1'b0;
      cmd_packet <= '0;
      rsp_buf    <= '0;
    end else begin
      index_q    <= index_n;
      hs2_q      <= hs2_n;
      ack_q      <= ack_n;
      oe_q       <= oe_n;
      data_out_q <= data_out_n;
      cmd_valid  <= cmd_valid_n;
      error      <= error_n;
      if ((state_n != state_q) || abort) timer_q <= '0;
      else if (busy_state)               timer_q <= timer_q + 1'b1;
      if (wr_latch) begin
        for (int i = 0; i < N_WRITE_BYTES; i++) begin
          if (index_q == IDX_W'(i)) cmd_packet[8*i +: 8] <= uP_data_in;
        end
      end
      if (rsp_latch) rsp_buf <= rsp_packet;
    end
  end

  // The bus is never driven while the uP claims it, even before the abort lands.
  assign uP_data_oe     = oe_q & ~s_rw;
  assign uP_data_out    = data_out_q;
  assign uP_handshake_2 = hs2_q;
  assign uP_ack         = ack_q;
  assign busy           = busy_state;

endmodule

// File: tb/tb_up_packet_interface.sv
// Directed bench for up_packet_interface: a 6/8-byte port with a short timeout
// and a 2/3-byte port share the uP-side stimulus; sel_b picks which is observed.
module tb_up_packet_interface;

  localparam int NWA = 6;
  localparam int NRA = 8;
  localparam int NWB = 2;
  localparam int NRB = 3;
  localparam int TO  = 50;

  localparam int SIG_HS2 = 0;
  localparam int SIG_ACK = 1;
  localparam int SIG_ERR = 2;
  localparam int SIG_CV  = 3;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset, start, h1, rw, sel_b;
  logic [7:0] data_in;
  logic rsp_valid;

  logic [7:0] dout_a, dout_b;
  logic oe_a, hs2_a, ack_a, cv_a, busy_a, err_a;
  logic oe_b, hs2_b, ack_b, cv_b, busy_b, err_b;
  logic [8*NWA-1:0] cmd_a;
  logic [8*NRA-1:0] rsp_a;
  logic [8*NWB-1:0] cmd_b;
  logic [8*NRB-1:0] rsp_b;

  logic [7:0] dout_m;
  logic oe_m, hs2_m, ack_m, cv_m, busy_m, err_m;

  int checks = 0;
  int passes = 0;
  int cv_cnt = 0;
  int err_cnt = 0;
  int oe_viol = 0;

  up_packet_interface #(
    .N_WRITE_BYTES(NWA), .N_READ_BYTES(NRA), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
  ) dut_a (
    .clk(clk), .reset(reset),
    .async_uP_start(start), .async_uP_handshake_1(h1), .async_uP_RW(rw),
    .uP_data_in(data_in), .uP_data_out(dout_a), .uP_data_oe(oe_a),
    .uP_handshake_2(hs2_a), .uP_ack(ack_a),
    .cmd_packet(cmd_a), .cmd_valid(cv_a),
    .rsp_packet(rsp_a), .rsp_valid(rsp_valid),
    .busy(busy_a), .error(err_a)
  );

  up_packet_interface #(
    .N_WRITE_BYTES(NWB), .N_READ_BYTES(NRB), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
  ) dut_b (
    .clk(clk), .reset(reset),
    .async_uP_start(start), .async_uP_handshake_1(h1), .async_uP_RW(rw),
    .uP_data_in(data_in), .uP_data_out(dout_b), .uP_data_oe(oe_b),
    .uP_handshake_2(hs2_b), .uP_ack(ack_b),
    .cmd_packet(cmd_b), .cmd_valid(cv_b),
    .rsp_packet(rsp_b), .rsp_valid(rsp_valid),
    .busy(busy_b), .error(err_b)
  );

  assign dout_m = sel_b ? dout_b : dout_a;
  assign oe_m   = sel_b ? oe_b   : oe_a;
  assign hs2_m  = sel_b ? hs2_b  : hs2_a;
  assign ack_m  = sel_b ? ack_b  : ack_a;
  assign cv_m   = sel_b ? cv_b   : cv_a;
  assign busy_m = sel_b ? busy_b : busy_a;
  assign err_m  = sel_b ? err_b  : err_a;

  // Running tallies of pulses on the large port and bus-contention events.
  always @(negedge clk) begin
    if (cv_a) cv_cnt++;
    if (err_a) err_cnt++;
    if (rw && oe_m) oe_viol++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic pickSig(input int which);
    case (which)
      SIG_HS2: return hs2_m;
      SIG_ACK: return ack_m;
      SIG_ERR: return err_m;
      default: return cv_m;
    endcase
  endfunction

  task automatic waitSig(input int which, input logic v, input string tag);
    int n = 0;
    while (pickSig(which) !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(pickSig(which)), 64'(v));
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic startPacket();
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic writeByte(input logic [7:0] b, input bit last);
    int n = 0;
    @(negedge clk);
    data_in = b;
    rw = 1'b1;
    @(negedge clk);
    h1 = 1'b1;
    waitSig(SIG_HS2, 1'b1, "w_hs2_rise");
    @(negedge clk);
    h1 = 1'b0;
    if (last) begin
      rw = 1'b0;
      do begin
        @(negedge clk);
        n++;
      end while (!cv_m && n < 20);
      checkOutput("cv_latency", 64'(n), 64'd3);
      checkOutput("w_hs2_fall_last", 64'(hs2_m), 64'd0);
    end else begin
      waitSig(SIG_HS2, 1'b0, "w_hs2_fall");
    end
  endtask

  task automatic readByte(input logic [7:0] exp);
    waitSig(SIG_HS2, 1'b1, "r_hs2_rise");
    checkOutput("rd_data", 64'(dout_m), 64'(exp));
    checkOutput("rd_oe", 64'(oe_m), 64'd1);
    h1 = 1'b1;
    waitSig(SIG_HS2, 1'b0, "r_hs2_fall");
    @(negedge clk);
    h1 = 1'b0;
  endtask

  task automatic writePacket(input logic [127:0] wbytes, input int nw);
    logic [127:0] w;
    w = wbytes;
    for (int i = 0; i < nw; i++) begin
      writeByte(w[7:0], i == nw - 1);
      w = w >> 8;
    end
  endtask

  task automatic readPacket(input logic [127:0] rbytes, input int nr);
    logic [127:0] r;
    r = rbytes;
    for (int i = 0; i < nr; i++) begin
      readByte(r[7:0]);
      r = r >> 8;
    end
  endtask

  task automatic applyStimulus(input bit do_start, input logic [127:0] wbytes, input int nw,
                               input logic [127:0] rbytes, input int nr);
    if (do_start) startPacket();
    writePacket(wbytes, nw);
    readPacket(rbytes, nr);
    checkOutput("ack_early", 64'(ack_m), 64'd0);
    waitSig(SIG_ACK, 1'b1, "ack_rise");
    checkOutput("oe_done", 64'(oe_m), 64'd0);
    checkOutput("busy_done", 64'(busy_m), 64'd0);
  endtask

  initial begin
    int c0, e0, d;
    reset = 1'b1; start = 1'b0; h1 = 1'b0; rw = 1'b0; data_in = 8'h00;
    sel_b = 1'b0; rsp_valid = 1'b1; rsp_a = '0; rsp_b = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_dout", 64'(dout_a), 64'd0);
    checkOutput("rst_oe", 64'(oe_a), 64'd0);
    checkOutput("rst_hs2", 64'(hs2_a), 64'd0);
    checkOutput("rst_ack", 64'(ack_a), 64'd0);
    checkOutput("rst_cv", 64'(cv_a), 64'd0);
    checkOutput("rst_busy", 64'(busy_a), 64'd0);
    checkOutput("rst_err", 64'(err_a), 64'd0);
    checkOutput("rst_cmd", 64'(cmd_a), 64'd0);
    reset = 1'b0;

    $display("[TB] write PWM_PERIOD=100 and read back");
    rsp_a = 64'h00000000_00000064;
    c0 = cv_cnt;
    applyStimulus(1'b1, 128'h00_00_00_64_10_01, NWA, 128'h00000000_00000064, NRA);
    checkOutput("t1_cmd", 64'(cmd_a), 64'h0000_0064_1001);
    checkOutput("t1_cv_count", 64'(cv_cnt - c0), 64'd1);

    $display("[TB] write/read 0xA5C31E7F");
    rsp_a = 64'h00000001_A5C31E7F;
    applyStimulus(1'b1, 128'hA5_C3_1E_7F_20_01, NWA, 128'h00000001_A5C31E7F, NRA);
    checkOutput("t2_cmd", 64'(cmd_a), 64'hA5C3_1E7F_2001);

    $display("[TB] 2-byte command, 3-byte response");
    resetDut();
    sel_b = 1'b1;
    rsp_b = 24'hCC_BB_AA;
    applyStimulus(1'b1, 128'h33_02, NWB, 128'hCC_BB_AA, NRB);
    checkOutput("t3_cmd", 64'(cmd_b), 64'h3302);
    sel_b = 1'b0;

    $display("[TB] handshake timeout");
    resetDut();
    startPacket();
    writeByte(8'h01, 1'b0);
    @(negedge clk);
    data_in = 8'h40;
    rw = 1'b1;
    @(negedge clk);
    h1 = 1'b1;
    waitSig(SIG_HS2, 1'b1, "to_hs2_rise");
    d = 0;
    do begin
      @(negedge clk);
      d++;
    end while (!err_a && d < 200);
    checkOutput("to_delay", 64'(d), 64'd50);
    checkOutput("to_hs2", 64'(hs2_a), 64'd0);
    checkOutput("to_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    checkOutput("to_err_pulse", 64'(err_a), 64'd0);
    h1 = 1'b0;
    rw = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("to_idle", 64'(busy_a), 64'd0);

    $display("[TB] restart during byte 4");
    c0 = cv_cnt;
    e0 = err_cnt;
    rsp_a = 64'h00000002_44332211;
    startPacket();
    writeByte(8'h01, 1'b0);
    writeByte(8'h02, 1'b0);
    writeByte(8'h03, 1'b0);
    @(negedge clk);
    data_in = 8'h04;
    start = 1'b1;
    waitSig(SIG_ERR, 1'b1, "rs_err");
    checkOutput("rs_busy", 64'(busy_a), 64'd1);
    checkOutput("rs_hs2", 64'(hs2_a), 64'd0);
    start = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 128'h44_33_22_11_30_01, NWA, 128'h00000002_44332211, NRA);
    checkOutput("rs_cmd", 64'(cmd_a), 64'h4433_2211_3001);
    checkOutput("rs_cv_count", 64'(cv_cnt - c0), 64'd1);
    checkOutput("rs_err_count", 64'(err_cnt - e0), 64'd1);

    $display("[TB] reset during read byte 5");
    startPacket();
    writePacket(128'h44_33_22_11_30_01, NWA);
    readPacket(128'h44332211, 4);
    waitSig(SIG_HS2, 1'b1, "mr_hs2_rise");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mr_dout", 64'(dout_a), 64'd0);
    checkOutput("mr_oe", 64'(oe_a), 64'd0);
    checkOutput("mr_hs2", 64'(hs2_a), 64'd0);
    checkOutput("mr_ack", 64'(ack_a), 64'd0);
    checkOutput("mr_busy", 64'(busy_a), 64'd0);
    checkOutput("mr_cmd", 64'(cmd_a), 64'd0);
    reset = 1'b0;
    rsp_a = 64'h00000000_00000064;
    applyStimulus(1'b1, 128'h00_00_00_64_10_01, NWA, 128'h00000000_00000064, NRA);
    checkOutput("mr_cmd_after", 64'(cmd_a), 64'h0000_0064_1001);

    checkOutput("oe_while_rw", 64'(oe_viol), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
